// File: rtl/multicycle_control_if.sv
// Bundle between the instruction register / datapath and the multicycle controller.
// The controller takes the master view; whatever drives opcode/funct/stall takes the slave view.
interface multicycle_control_if #(
  parameter int CNT_WIDTH = 32
);
  logic [5:0]           opcode;
  logic [5:0]           funct;
  logic                 stall;
  logic [2:0]           state;
  logic [1:0]           RegDst;
  logic                 ALUSrc;
  logic [2:0]           ALUcntrl;
  logic [1:0]           MemToReg;
  logic                 jump;
  logic                 beq;
  logic                 bne;
  logic                 RegWr;
  logic                 MemWr;
  logic                 instrReg;
  logic                 PCReg;
  logic                 addrGen;
  logic                 R_rsReg;
  logic                 R_rtReg;
  logic                 illegal;
  logic [CNT_WIDTH-1:0] retired;

  modport master (
    input  opcode, funct, stall,
    output state, RegDst, ALUSrc, ALUcntrl, MemToReg, jump, beq, bne,
           RegWr, MemWr, instrReg, PCReg, addrGen, R_rsReg, R_rtReg,
           illegal, retired
  );

  modport slave (
    output opcode, funct, stall,
    input  state, RegDst, ALUSrc, ALUcntrl, MemToReg, jump, beq, bne,
           RegWr, MemWr, instrReg, PCReg, addrGen, R_rsReg, R_rtReg,
           illegal, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle CPU control sequencer: IF/ID/EX/MEM/WB with memory wait states,
// global stall, single-cycle strobes, sticky trap and a retired-instruction counter.
module multicycle_control #(
  parameter int IF_WAIT   = 0,
  parameter int MEM_WAIT  = 0,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  localparam int WMAX = (IF_WAIT > MEM_WAIT) ? IF_WAIT : MEM_WAIT;
  localparam int WW   = (WMAX < 1) ? 1 : $clog2(WMAX + 1);
  localparam logic [WW-1:0] IF_LAST  = WW'(IF_WAIT);
  localparam logic [WW-1:0] MEM_LAST = WW'(MEM_WAIT);

  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5
  } state_t;

  // P_NONE doubles as the "undecoded" marker that sends ID into TRAP.
  typedef enum logic [2:0] {
    P_NONE, P_JUMP, P_JAL, P_BRANCH, P_ALU, P_LOAD, P_STORE
  } path_t;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic       alu_src;
    logic [2:0] alu_cntrl;
    logic [1:0] mem_to_reg;
    logic       jump;
    logic       beq;
    logic       bne;
    path_t      path;
  } decode_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   cnt_q, cnt_d;
  decode_t         dec, dec_q;
  logic [CNT_WIDTH-1:0] retired_q;

  logic instr_raw, addr_raw, rs_raw, mem_wr_raw, reg_wr_raw, pc_raw;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    dec = '0;
    if (bus.opcode == 6'h00) begin
      case (bus.funct)
        6'h20: dec.path = P_ALU;
        6'h22: begin dec.path = P_ALU; dec.alu_cntrl = 3'd1; end
        6'h2a: begin dec.path = P_ALU; dec.alu_cntrl = 3'd3; end
        6'h08: begin dec.path = P_JUMP; dec.jump = 1'b1; end
        default: ;
      endcase
    end else begin
      case (bus.opcode)
        6'h23: begin
          dec.path = P_LOAD; dec.reg_dst = 2'd2; dec.alu_src = 1'b1; dec.mem_to_reg = 2'd1;
        end
        6'h2b: begin dec.path = P_STORE; dec.alu_src = 1'b1; end
        6'h02: begin dec.path = P_JUMP; dec.jump = 1'b1; end
        6'h03: begin
          dec.path = P_JAL; dec.reg_dst = 2'd1; dec.mem_to_reg = 2'd2; dec.jump = 1'b1;
        end
        6'h04: begin dec.path = P_BRANCH; dec.alu_cntrl = 3'd1; dec.beq = 1'b1; end
        6'h05: begin dec.path = P_BRANCH; dec.alu_cntrl = 3'd1; dec.bne = 1'b1; end
        6'h0e: begin
          dec.path = P_ALU; dec.reg_dst = 2'd2; dec.alu_src = 1'b1; dec.alu_cntrl = 3'd2;
        end
        6'h08: begin dec.path = P_ALU; dec.reg_dst = 2'd2; dec.alu_src = 1'b1; end
        default: ;
      endcase
    end
  end

  // Next state and unstalled strobes; ID uses the live decode, later states the latched path.
  always_comb begin
    state_d    = state_q;
    instr_raw  = 1'b0;
    addr_raw   = 1'b0;
    rs_raw     = 1'b0;
    mem_wr_raw = 1'b0;
    reg_wr_raw = 1'b0;
    pc_raw     = 1'b0;
    case (state_q)
      S_IF: begin
        if (cnt_q == IF_LAST) begin
          instr_raw = 1'b1;
          state_d   = S_ID;
        end
      end
      S_ID: begin
        addr_raw = 1'b1;
        case (dec.path)
          P_NONE:  state_d = S_TRAP;
          P_JUMP:  begin state_d = S_IF; pc_raw = 1'b1; end
          P_JAL:   state_d = S_WB;
          default: state_d = S_EX;
        endcase
      end
      S_EX: begin
        rs_raw = 1'b1;
        case (dec_q.path)
          P_BRANCH:        begin state_d = S_IF; pc_raw = 1'b1; end
          P_LOAD, P_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_wr_raw = (dec_q.path == P_STORE);
        if (cnt_q == MEM_LAST) begin
          if (dec_q.path == P_STORE) begin
            state_d = S_IF;
            pc_raw  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_wr_raw = 1'b1;
        pc_raw     = 1'b1;
        state_d    = S_IF;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IF;
    endcase

    cnt_d = cnt_q;
    if (state_d != state_q)                        cnt_d = '0;
    else if (state_q == S_IF || state_q == S_MEM)  cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IF;
      cnt_q     <= '0;
      dec_q     <= '0;
      retired_q <= '0;
    end else if (!bus.stall) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_ID) dec_q <= dec;
      if (pc_raw)          retired_q <= retired_q + 1'b1;
    end
  end

  assign bus.state    = state_q;
  assign bus.RegDst   = dec_q.reg_dst;
  assign bus.ALUSrc   = dec_q.alu_src;
  assign bus.ALUcntrl = dec_q.alu_cntrl;
  assign bus.MemToReg = dec_q.mem_to_reg;
  assign bus.jump     = dec_q.jump;
  assign bus.beq      = dec_q.beq;
  assign bus.bne      = dec_q.bne;
  assign bus.illegal  = (state_q == S_TRAP);
  assign bus.retired  = retired_q;

  assign bus.instrReg = instr_raw  & ~bus.stall;
  assign bus.addrGen  = addr_raw   & ~bus.stall;
  assign bus.R_rsReg  = rs_raw     & ~bus.stall;
  assign bus.R_rtReg  = rs_raw     & ~bus.stall;
  assign bus.MemWr    = mem_wr_raw & ~bus.stall;
  assign bus.RegWr    = reg_wr_raw & ~bus.stall;
  assign bus.PCReg    = pc_raw     & ~bus.stall;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: two configurations (waits 0/0 and 1/2),
// each cycle compared against a phase-list reference model of the instruction.
module tb_multicycle_control;

  localparam int CW = 32;
  localparam int B_IR = 6, B_AG = 5, B_RS = 4, B_RT = 3, B_MW = 2, B_RW = 1, B_PC = 0;

  logic       clk = 1'b0;
  logic       reset;
  logic       sel;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       stall;

  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_WIDTH(CW)) bus0 ();
  multicycle_control_if #(.CNT_WIDTH(CW)) bus1 ();

  assign bus0.opcode = opcode;
  assign bus0.funct  = funct;
  assign bus0.stall  = stall;
  assign bus1.opcode = opcode;
  assign bus1.funct  = funct;
  assign bus1.stall  = stall;

  multicycle_control #(.IF_WAIT(0), .MEM_WAIT(0), .CNT_WIDTH(CW)) dut0 (
    .clk(clk), .reset(reset | sel), .bus(bus0)
  );
  multicycle_control #(.IF_WAIT(1), .MEM_WAIT(2), .CNT_WIDTH(CW)) dut1 (
    .clk(clk), .reset(reset | ~sel), .bus(bus1)
  );

  // Outputs of whichever configuration is under test.
  logic [2:0]    o_state;
  logic [6:0]    o_strb;
  logic [10:0]   o_dec;
  logic          o_ill;
  logic [CW-1:0] o_ret;

  always_comb begin
    if (sel) begin
      o_state = bus1.state;
      o_strb  = {bus1.instrReg, bus1.addrGen, bus1.R_rsReg, bus1.R_rtReg,
                 bus1.MemWr, bus1.RegWr, bus1.PCReg};
      o_dec   = {bus1.RegDst, bus1.ALUSrc, bus1.ALUcntrl, bus1.MemToReg,
                 bus1.jump, bus1.beq, bus1.bne};
      o_ill   = bus1.illegal;
      o_ret   = bus1.retired;
    end else begin
      o_state = bus0.state;
      o_strb  = {bus0.instrReg, bus0.addrGen, bus0.R_rsReg, bus0.R_rtReg,
                 bus0.MemWr, bus0.RegWr, bus0.PCReg};
      o_dec   = {bus0.RegDst, bus0.ALUSrc, bus0.ALUcntrl, bus0.MemToReg,
                 bus0.jump, bus0.beq, bus0.bne};
      o_ill   = bus0.illegal;
      o_ret   = bus0.retired;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an instruction is a list of cycles, each with its state and strobes.
  typedef struct {
    int         st;
    logic [6:0] strb;
  } cyc_t;

  cyc_t q[$];
  int   w_if, w_mem;
  int   exp_ret;

  function automatic bit decode_ref(input logic [5:0] op, input logic [5:0] fn,
                                    output logic [10:0] d,
                                    output bit ex, output bit mem, output bit wb, output bit sw);
    logic [1:0] rd = 2'd0, m2r = 2'd0;
    logic       src = 1'b0, j = 1'b0, bq = 1'b0, bn = 1'b0;
    logic [2:0] alu = 3'd0;
    bit         ok = 1'b1;
    ex = 0; mem = 0; wb = 0; sw = 0;
    if (op == 6'h00) begin
      case (fn)
        6'h20: begin ex = 1; wb = 1; end
        6'h22: begin ex = 1; wb = 1; alu = 3'd1; end
        6'h2a: begin ex = 1; wb = 1; alu = 3'd3; end
        6'h08: j = 1'b1;
        default: ok = 1'b0;
      endcase
    end else begin
      case (op)
        6'h23: begin ex = 1; mem = 1; wb = 1; rd = 2'd2; src = 1'b1; m2r = 2'd1; end
        6'h2b: begin ex = 1; mem = 1; sw = 1; src = 1'b1; end
        6'h02: j = 1'b1;
        6'h03: begin wb = 1; rd = 2'd1; m2r = 2'd2; j = 1'b1; end
        6'h04: begin ex = 1; alu = 3'd1; bq = 1'b1; end
        6'h05: begin ex = 1; alu = 3'd1; bn = 1'b1; end
        6'h0e: begin ex = 1; wb = 1; rd = 2'd2; src = 1'b1; alu = 3'd2; end
        6'h08: begin ex = 1; wb = 1; rd = 2'd2; src = 1'b1; end
        default: ok = 1'b0;
      endcase
    end
    d = ok ? {rd, src, alu, m2r, j, bq, bn} : 11'd0;
    return ok;
  endfunction

  task automatic push(input int st, input logic [6:0] strb);
    cyc_t c;
    c.st   = st;
    c.strb = strb;
    q.push_back(c);
  endtask

  // Runs one instruction from its first IF cycle; called and returning on a falling edge.
  // mode 0: no stall, 1: random stall, 2: stall for 3 cycles at WB.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int mode);
    logic [10:0] d;
    bit   ok, ex, mem, wb, sw;
    cyc_t c;
    int   guard = 0;
    int   held  = 0;
    ok = decode_ref(op, fn, d, ex, mem, wb, sw);
    for (int i = 0; i <= w_if; i++) push(0, (i == w_if) ? 7'(1 << B_IR) : 7'd0);
    push(1, 7'(1 << B_AG));
    if (ok) begin
      if (ex) push(2, 7'((1 << B_RS) | (1 << B_RT)));
      if (mem) for (int i = 0; i <= w_mem; i++) push(3, sw ? 7'(1 << B_MW) : 7'd0);
      if (wb) push(4, 7'(1 << B_RW));
      c = q.pop_back();
      c.strb[B_PC] = 1'b1;
      q.push_back(c);
    end
    while (q.size() > 0 && guard < 200) begin
      if (q[0].st == 1) begin
        opcode = op;
        funct  = fn;
      end else begin
        opcode = 6'($urandom);
        funct  = 6'($urandom);
      end
      case (mode)
        1:       stall = ($urandom_range(0, 3) == 0);
        2:       stall = (q[0].st == 4 && held < 3);
        default: stall = 1'b0;
      endcase
      if (stall && mode == 2) held++;
      #1;
      check("state", 32'(o_state), 32'(q[0].st));
      check("illegal", 32'(o_ill), 0);
      check("retired", o_ret, 32'(exp_ret));
      if (stall) begin
        check("strobes_stalled", 32'(o_strb), 0);
      end else begin
        check("strobes", 32'(o_strb), 32'(q[0].strb));
        if (q[0].strb[B_PC]) exp_ret++;
        void'(q.pop_front());
      end
      guard++;
      @(negedge clk);
    end
    stall = 1'b0;
    check("instr_drained", 32'(q.size()), 0);
    q.delete();
    if (ok) begin
      check("decode", 32'(o_dec), 32'(d));
      check("back_to_if", 32'(o_state), 0);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after reset is released.
  task automatic do_reset(input logic which);
    sel    = which;
    reset  = 1'b1;
    stall  = 1'($urandom);
    opcode = 6'($urandom);
    funct  = 6'($urandom);
    @(posedge clk);
    #1;
    check("rst_state", 32'(o_state), 0);
    check("rst_retired", o_ret, 0);
    check("rst_illegal", 32'(o_ill), 0);
    check("rst_decode", 32'(o_dec), 0);
    @(negedge clk);
    reset   = 1'b0;
    stall   = 1'b0;
    exp_ret = 0;
  endtask

  // Entered on the first TRAP cycle: TRAP must hold for 5 cycles, then reset clears it.
  task automatic trap_then_reset();
    for (int i = 0; i < 5; i++) begin
      stall  = 1'($urandom);
      opcode = 6'($urandom);
      funct  = 6'($urandom);
      #1;
      check("trap_state", 32'(o_state), 5);
      check("trap_illegal", 32'(o_ill), 1);
      check("trap_strobes", 32'(o_strb), 0);
      check("trap_decode", 32'(o_dec), 0);
      check("trap_retired", o_ret, 32'(exp_ret));
      @(negedge clk);
    end
    do_reset(sel);
  endtask

  task automatic run_random(input int n);
    logic [5:0] ops[12] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h2b,
                            6'h02, 6'h03, 6'h04, 6'h05, 6'h0e, 6'h08};
    logic [5:0] fns[4]  = '{6'h20, 6'h22, 6'h2a, 6'h08};
    int k;
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 11);
      run_instr(ops[k], (k < 4) ? fns[k] : 6'($urandom), 1);
    end
  endtask

  task automatic run_random_illegal();
    logic [10:0] d;
    bit ex, mem, wb, sw;
    logic [5:0] op, fn;
    int tries = 0;
    do begin
      op = 6'($urandom);
      fn = 6'($urandom);
      tries++;
    end while (decode_ref(op, fn, d, ex, mem, wb, sw) && tries < 100);
    run_instr(op, fn, 1);
    trap_then_reset();
  endtask

  initial begin
    reset  = 1'b1;
    sel    = 1'b0;
    stall  = 1'b0;
    opcode = 6'd0;
    funct  = 6'd0;
    q.delete();

    w_if = 0; w_mem = 0;
    do_reset(1'b0);
    run_instr(6'h00, 6'h20, 0);
    check("add_retired", o_ret, 1);
    run_instr(6'h02, 6'h15, 0);
    run_instr(6'h04, 6'h2a, 0);
    run_instr(6'h03, 6'h00, 0);
    run_instr(6'h08, 6'h3c, 2);
    run_random(30);
    run_instr(6'h3f, 6'h00, 0);
    trap_then_reset();
    run_instr(6'h00, 6'h01, 1);
    trap_then_reset();

    w_if = 1; w_mem = 2;
    do_reset(1'b1);
    run_instr(6'h23, 6'h11, 0);
    run_instr(6'h2b, 6'h22, 0);
    check("lw_sw_retired", o_ret, 2);
    run_instr(6'h08, 6'h07, 2);
    run_random(30);
    run_random_illegal();
    run_instr(6'h00, 6'h2a, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multicycle CPU control FSM, the next generation of the team's five-state IF/ID/EX/MEM/WB sequencer. Same opcode set and datapath control encoding, plus:
- configurable wait states for slow instruction and data memories;
- a global stall input;
- single-cycle write-enable strobes instead of levels held across the instruction;
- a sticky trap state for undecoded instructions;
- a retired-instruction counter.

It sits between the instruction register (opcode/funct) and the multicycle datapath.

## Interface
Parameters:
- IF_WAIT, default 0: extra cycles IF is held beyond one (instruction memory latency).
- MEM_WAIT, default 0: extra cycles MEM is held beyond one (data memory latency).
- CNT_WIDTH, default 32: width of retired-instruction counter.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state changes on rising edge.
- reset  in  1  synchronous active-high reset.
- opcode  in  6  instruction opcode, sampled in ID.
- funct  in  6  R-type funct, sampled in ID.
- stall  in  1  when high, freeze all sequential state and suppress strobes.
- state  out  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=5.
- RegDst  out  2  registered decode: 0 rd, 1 r31, 2 rt.
- ALUSrc  out  1  registered decode: 1 selects immediate.
- ALUcntrl  out  3  registered decode: 0 add, 1 sub, 2 xor, 3 slt.
- MemToReg  out  2  registered decode: 0 ALU, 1 memory, 2 PC+4.
- jump, beq, bne  out  1 each  registered decode flags.
- RegWr  out  1  strobe: register file write.
- MemWr  out  1  strobe: data memory write.
- instrReg  out  1  strobe: instruction register load.
- PCReg  out  1  strobe: PC update.
- addrGen  out  1  strobe: branch/jump target generation.
- R_rsReg, R_rtReg  out  1 each  strobe: operand register load.
- illegal  out  1  high while in TRAP.
- retired  out  CNT_WIDTH  count of completed instructions.

## Operation
- Decode in ID latches all registered fields and a path code:
  - ADD 0x20: ALUcntrl 0, IF→ID→EX→WB.
  - SUB 0x22: ALUcntrl 1, IF→ID→EX→WB.
  - SLT 0x2a: ALUcntrl 3, IF→ID→EX→WB.
  - JR 0x08: jump, IF→ID.
  - LW 0x23: RegDst 2, ALUSrc, MemToReg 1, IF→ID→EX→MEM→WB.
  - SW 0x2b: ALUSrc, IF→ID→EX→MEM.
  - J 0x2: jump, IF→ID.
  - JAL 0x3: RegDst 1, MemToReg 2, jump, IF→ID→WB.
  - BEQ 0x4: ALUcntrl 1, beq, IF→ID→EX.
  - BNE 0x5: ALUcntrl 1, bne, IF→ID→EX.
  - XORI 0xe: RegDst 2, ALUSrc, ALUcntrl 2, IF→ID→EX→WB.
  - ADDI 0x8: RegDst 2, ALUSrc, ALUcntrl 0, IF→ID→EX→WB.
- Any fields not listed above decode to 0.
- Any other opcode, or any other funct with opcode 0, goes ID→TRAP with all decode fields cleared. TRAP is left only by reset.
- Strobes are combinational from the state register, counter and path code, ANDed with !stall:
  - instrReg: on the last IF cycle (wait counter == IF_WAIT).
  - addrGen: in ID.
  - R_rsReg and R_rtReg: in EX.
  - MemWr: on every MEM cycle of SW.
  - RegWr: in WB.
  - PCReg: on the final cycle of each instruction, i.e. the cycle whose successor is IF. That is ID for J/JR, EX for BEQ/BNE, the last MEM cycle for SW, and WB otherwise.
- Wait counter:
  - Clears on entry to IF and to MEM.
  - Increments each unstalled cycle in those states.
  - IF exits when the counter equals IF_WAIT; MEM exits when it equals MEM_WAIT.
  - Sized to hold max(IF_WAIT, MEM_WAIT).
- retired increments, modulo 2^CNT_WIDTH, on every cycle where PCReg is high.

## Timing
- Reset (synchronous) sets, at the next edge:
  - state=IF, wait counter 0, retired 0, all registered decode fields 0, path code cleared, illegal 0.
- Reset overrides stall, including mid-instruction and in TRAP.
- In the cycle after reset, with IF_WAIT=0 and stall=0, instrReg is high.
- Cycles per instruction, with W=IF_WAIT and M=MEM_WAIT:
  - J, JR: 2+W.
  - JAL, BEQ, BNE: 3+W.
  - R-type, ADDI, XORI: 4+W.
  - SW: 4+W+M.
  - LW: 5+W+M.
- Stall: state, counter, decode registers and retired hold; all strobes read 0. A stall asserted on a strobe cycle delays that strobe until stall drops. No strobe is lost or duplicated.
- opcode and funct need be valid only during ID; decode fields stay stable from the cycle after ID until the next ID.

## Test plan
- IF_WAIT=0, ADD: state sequence 0,1,2,4,0. instrReg in cycle 1, addrGen in cycle 2, R_rsReg and R_rtReg in cycle 3, RegWr and PCReg in cycle 4 only, ALUcntrl=0. retired goes 0→1.
- IF_WAIT=1, MEM_WAIT=2, LW: 8 cycles, states 0,0,1,2,3,3,3,4. MemWr never high, MemToReg=1, RegDst=2.
- IF_WAIT=1, MEM_WAIT=2, SW: 7 cycles. MemWr high for exactly 3 cycles, PCReg on the third MEM cycle, RegWr never high.
- Program J, BEQ, JAL with IF_WAIT=0: cycle counts 2, 3, 3. retired=3. RegWr only in the JAL WB cycle, with RegDst=1 and MemToReg=2.
- Stall held 3 cycles during the WB of ADDI: state stays 4, RegWr low for the 3 cycles then high for exactly one cycle. retired increments once.
- Opcode 0x3f, then reset asserted 5 cycles later: state=5 and illegal=1 from the cycle after ID, no further strobes. The edge after reset gives state 0, retired 0, illegal 0.
